uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
UART byte transmitter that serialises one 8-bit byte per request as an 8N1 frame: start bit 0, D0..D7 LSB first, stop bit 1. It is the transmit counterpart of uart_byte_rx in the UART2SPI bridge. It uses the same 3-bit Baud_Set encoding and the same 50 MHz system clock, and returns bytes from the SPI side to the host.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency used to derive bit-period divisors.

Ports:
Clk  input  1  system clock, rising-edge.
Reset_n  input  1  asynchronous active-low reset.
Baud_Set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 = 9600.
Send_En  input  1  one-cycle request to transmit Data; accepted only while uart_state=0.
Data  input  8  byte to send; sampled on the accepted Send_En cycle.
uart_tx  output  1  serial line, idle high.
Tx_Done  output  1  one-cycle pulse after the stop bit completes.
uart_state  output  1  busy flag, high from acceptance to the end of the stop bit.

Behaviour:
- Reset: Clk and Reset_n, asynchronous, active-low. All outputs are driven to their reset values: uart_tx=1, Tx_Done=0, uart_state=0, FSM=IDLE, counters=0, latched data=0.
- Bit period BIT_CYC = CLK_FREQ_HZ / baud, using integer division. Divisor register BAUD_DIV = BIT_CYC-1, 16 bits wide.
  - At 50 MHz: 9600 gives 5207; 19200 gives 2603; 38400 gives 1301; 57600 gives 867; 115200 gives 433.
- Acceptance: Send_En=1 and uart_state=0 at edge T.
  - Data and Baud_Set are latched.
  - uart_state=1 and uart_tx=0 (start bit) from T+1.
- Send_En while uart_state=1 is ignored. Data and Baud_Set changes mid-frame have no effect.
- FSM states:
  - IDLE: uart_tx=1. Go to START on acceptance.
  - START: uart_tx=0 for BIT_CYC cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=latched[bit_idx] for BIT_CYC cycles each. Increment bit_idx (3 bits). After bit_idx=7 completes, go to STOP.
  - STOP: uart_tx=1 for BIT_CYC cycles, then go to IDLE.
- Divider counter: runs 0..BAUD_DIV only in non-IDLE states. At terminal count it wraps to 0 and advances the bit. It is held at 0 in IDLE.
- Frame length: 10*BIT_CYC cycles from T+1. uart_state falls and Tx_Done pulses high in the same cycle, the first IDLE cycle.
- Back-to-back frames:
  - A Send_En coincident with the Tx_Done cycle is accepted, because uart_state is already 0.
  - The next start bit then begins one cycle later. Minimum inter-frame idle-high time is BIT_CYC+1 cycles (stop bit plus 1).
- All outputs are registered, with no combinational path from inputs to uart_tx.
- Reset asserted mid-frame: uart_tx goes to 1 immediately (asynchronously) and the frame is abandoned. No Tx_Done is issued.

Decomposition:
- Shared package uart_pkg:
  - Baud_Set encoding constants BAUD_9600..BAUD_115200.
  - Function baud_div(clk_hz, sel) returning the 16-bit BAUD_DIV.
  - FSM state typedef {IDLE, START, DATA, STOP}.
  - The receiver's Bps_DR table is to be migrated onto the same constants.
- One sub-module, uart_tx_baud_div:
  - Inputs: the latched 16-bit divisor and an enable.
  - Output: a one-cycle bit_tick at terminal count.
  - The FSM and shift logic stay in uart_byte_tx.

Test Plan:
- Reset then idle, no Send_En -> uart_tx=1, uart_state=0, Tx_Done=0 for 100 cycles.
- Baud_Set=0, Data=8'h55, Send_En pulse -> start low 5208 cycles, then bits 1,0,1,0,1,0,1,0 at 5208 cycles each, then stop high. Tx_Done pulses exactly 52081 cycles after the accepting edge. Loopback through uart_byte_rx yields Data=8'h55 with Rx_Done.
- Baud_Set=4, Data=8'hA3 -> each bit 434 cycles, frame 4340 cycles. Line pattern is 0,1,1,0,0,0,1,0,1,1.
- Baud_Set=7 -> timing identical to Baud_Set=0 (5208 cycles per bit).
- Send_En pulses with Data=8'hFF at mid-frame and Baud_Set changed 4->0 during a frame -> frame unchanged, no second frame started. Send_En on the Tx_Done cycle with Data=8'h00 -> start bit begins next cycle.
- Reset_n low during data bit 3 -> uart_tx=1 in the same cycle, no Tx_Done. A subsequent request transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART byte transmitter and receiver.
//   - Baud_Set encoding (3 bits). Codes 5..7 fall back to 9600.
//   - baud_div(): converts a clock frequency and a rate select into the 16-bit
//     bit-period divisor. The divisor is BIT_CYC-1, where BIT_CYC = clk_hz / baud
//     using integer division.
//   - tx_state_e: transmitter FSM states.
// uart_byte_rx is expected to build its Bps_DR table from these same constants.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // clk_hz is always a parameter at the call site. Each branch therefore folds
  // to a constant, and the hardware cost is just a mux of five values.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned bit_cyc;
    case (sel)
      BAUD_19200:  bit_cyc = clk_hz / 32'd19200;
      BAUD_38400:  bit_cyc = clk_hz / 32'd38400;
      BAUD_57600:  bit_cyc = clk_hz / 32'd57600;
      BAUD_115200: bit_cyc = clk_hz / 32'd115200;
      default:     bit_cyc = clk_hz / 32'd9600;
    endcase
    return 16'(bit_cyc - 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_baud_div.sv
// uart_tx_baud_div: bit-period divider for the UART transmitter.
//   Clk        - system clock, rising edge
//   Reset_n    - asynchronous active-low reset
//   en_i       - count enable (high while a frame is in flight)
//   div_i      - terminal count (BIT_CYC-1), held stable for the frame
//   bit_tick_o - one-cycle pulse in the last cycle of each bit period
// The counter runs 0..div_i while enabled. It wraps to 0 at terminal count
// and is held at 0 while disabled, so every frame starts on a fresh period.
module uart_tx_baud_div (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        en_i,
  input  logic [15:0] div_i,
  output logic        bit_tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        at_term;

  assign at_term = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (at_term) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = en_i & at_term;

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: transmits one 8N1 UART frame per request.
//   Clk        - system clock, rising edge
//   Reset_n    - asynchronous active-low reset
//   Baud_Set   - rate select (see uart_pkg), latched when a request is accepted
//   Send_En    - one-cycle request, accepted only while uart_state is low
//   Data       - byte to send, latched when a request is accepted
//   uart_tx    - serial line, idle high (registered)
//   Tx_Done    - one-cycle pulse in the first idle cycle after the stop bit
//   uart_state - busy flag, high from the cycle after acceptance through the stop bit
// The frame is: start bit 0, D0..D7 LSB first, stop bit 1. Each bit lasts
// BIT_CYC clock cycles. All outputs are flops. Their next values are computed
// from the next FSM state, so the line changes on the same edge as the state.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] Baud_Set,
  input  logic       Send_En,
  input  logic [7:0] Data,
  output logic       uart_tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  tx_state_e   state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q;
  logic [15:0] baud_div_q;
  logic        accept;
  logic        bit_tick;
  logic        uart_tx_d, tx_done_d, busy_d;

  // uart_state is low exactly when the FSM is in IDLE.
  // A request in the Tx_Done cycle is therefore accepted.
  assign accept = Send_En & (state_q == IDLE);

  uart_tx_baud_div u_baud_div (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .en_i       (state_q != IDLE),
    .div_i      (baud_div_q),
    .bit_tick_o (bit_tick)
  );

  // Request latch: changes to Data and Baud_Set mid-frame are invisible.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q     <= '0;
      baud_div_q <= '0;
    end else if (accept) begin
      data_q     <= Data;
      baud_div_q <= baud_div(CLK_FREQ_HZ, Baud_Set);
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. It is decoded from the next state so that the registered
  // outputs line up with state_q.
  always_comb begin
    uart_tx_d = 1'b1;
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_q == STOP) & bit_tick;
    unique case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = data_q[bit_idx_d];
      default: uart_tx_d = 1'b1;
    endcase
  end

  // Output registers. Reset forces the line high at once and abandons the frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      uart_tx    <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      uart_tx    <= uart_tx_d;
      Tx_Done    <= tx_done_d;
      uart_state <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx. The DUT runs at a reduced clock
// frequency so that 9600-baud frames stay short. Divisor values at 50 MHz are
// checked separately, directly against the package function.
module tb_uart_byte_tx;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 2000000;

  logic       Clk      = 1'b0;
  logic       Reset_n  = 1'b1;
  logic [2:0] Baud_Set = 3'd0;
  logic       Send_En  = 1'b0;
  logic [7:0] Data     = 8'h00;
  logic       uart_tx, Tx_Done, uart_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] div;
  } div_vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    int         bc;     // expected bit period in cycles
    bit         noise;  // inject an ignored request and a Baud_Set change mid-frame
    bit         chain;  // request the next frame in the Tx_Done cycle
  } frame_vec_t;

  div_vec_t   dv[8];
  frame_vec_t vq[$];

  uart_byte_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Baud_Set   (Baud_Set),
    .Send_En    (Send_En),
    .Data       (Data),
    .uart_tx    (uart_tx),
    .Tx_Done    (Tx_Done),
    .uart_state (uart_state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  // Reference model: bit period from the rate table, and line level from the
  // frame layout.
  function automatic int model_bit_cyc(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return int'(clk_hz / baud);
  endfunction

  // j = sample index, counted from the first negedge after the accepting edge.
  function automatic logic model_line(input int j, input int bc, input logic [7:0] d);
    int b;
    b = j / bc;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic drive_req(input frame_vec_t v);
    Send_En  = 1'b1;
    Data     = v.data;
    Baud_Set = v.sel;
  endtask

  // Entered at a negedge with the request already driven. The task returns at
  // a negedge. If chaining, it returns with the next request driven in the
  // Tx_Done cycle.
  task automatic run_frame(input frame_vec_t v, input bit chain, input frame_vec_t nv,
                           input string tag);
    int line_bad = -1;
    int busy_bad = -1;
    int done_at  = -1;
    int done_cnt = 0;
    int last;
    last = chain ? 10 * v.bc : 10 * v.bc + 1;
    @(posedge Clk);
    @(negedge Clk);
    Send_En = 1'b0;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge Clk);
      if (line_bad < 0 && uart_tx !== model_line(j, v.bc, v.data)) line_bad = j;
      if (busy_bad < 0 && uart_state !== (j < 10 * v.bc)) busy_bad = j;
      if (Tx_Done !== 1'b0) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (v.noise && j == 5 * v.bc) begin
        Send_En  = 1'b1;
        Data     = 8'hFF;
        Baud_Set = (v.sel == 3'd4) ? 3'd0 : 3'd4;
      end
      if (v.noise && j == 5 * v.bc + 1) Send_En = 1'b0;
      if (chain && j == 10 * v.bc) drive_req(nv);
    end
    check_int({tag, " first bad uart_tx sample"}, line_bad, -1);
    check_int({tag, " first bad uart_state sample"}, busy_bad, -1);
    check_int({tag, " Tx_Done sample index"}, done_at, 10 * v.bc);
    check_int({tag, " Tx_Done pulse count"}, done_cnt, 1);
  endtask

  task automatic run_queue(input string prefix);
    @(negedge Clk);
    drive_req(vq[0]);
    for (int i = 0; i < vq.size(); i++) begin
      int nxt;
      nxt = (i + 1 < vq.size()) ? i + 1 : i;
      run_frame(vq[i], vq[i].chain && (i + 1 < vq.size()), vq[nxt],
                $sformatf("%s%0d", prefix, i));
      if (!vq[i].chain && i + 1 < vq.size()) drive_req(vq[nxt]);
    end
  endtask

  initial begin
    int bad;
    int low_cnt;
    int done_cnt;
    frame_vec_t fv;

    // Reset state and a quiet idle line.
    #1 Reset_n = 1'b0;
    #11;
    check_bit("reset uart_tx", uart_tx, 1'b1);
    check_bit("reset Tx_Done", Tx_Done, 1'b0);
    check_bit("reset uart_state", uart_state, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge Clk);
      if (uart_tx !== 1'b1 || Tx_Done !== 1'b0 || uart_state !== 1'b0) bad++;
    end
    check_int("idle 100 cycles bad samples", bad, 0);

    // Divisors at 50 MHz.
    dv[0] = '{3'd0, 16'd5207};
    dv[1] = '{3'd1, 16'd2603};
    dv[2] = '{3'd2, 16'd1301};
    dv[3] = '{3'd3, 16'd867};
    dv[4] = '{3'd4, 16'd433};
    dv[5] = '{3'd5, 16'd5207};
    dv[6] = '{3'd6, 16'd5207};
    dv[7] = '{3'd7, 16'd5207};
    for (int i = 0; i < 8; i++) begin
      check_int($sformatf("baud_div 50MHz sel=%0d", dv[i].sel),
                int'(baud_div(32'd50000000, dv[i].sel)), int'(dv[i].div));
    end

    // Directed frames at 2 MHz: 9600 -> 208 cycles per bit ... 115200 -> 17 cycles per bit.
    vq.delete();
    vq.push_back('{3'd0, 8'h55, 208, 1'b0, 1'b0});
    vq.push_back('{3'd4, 8'hA3, 17, 1'b1, 1'b0});
    vq.push_back('{3'd4, 8'h55, 17, 1'b0, 1'b1});
    vq.push_back('{3'd4, 8'h00, 17, 1'b0, 1'b0});
    vq.push_back('{3'd7, 8'h3C, 208, 1'b0, 1'b0});
    vq.push_back('{3'd1, 8'h96, 104, 1'b0, 1'b0});
    vq.push_back('{3'd2, 8'h0F, 52, 1'b1, 1'b0});
    vq.push_back('{3'd3, 8'hF0, 34, 1'b0, 1'b1});
    vq.push_back('{3'd5, 8'hC3, 208, 1'b0, 1'b0});
    vq.push_back('{3'd6, 8'h81, 208, 1'b0, 1'b0});
    run_queue("vec");

    // Reset asserted during data bit 3 (8'hA3 has bit 3 = 0, so the line is low then).
    fv = '{3'd4, 8'hA3, 17, 1'b0, 1'b0};
    drive_req(fv);
    @(posedge Clk);
    @(negedge Clk);
    Send_En = 1'b0;
    repeat (4 * 17 + 5) @(negedge Clk);
    check_bit("pre-reset data bit 3 line", uart_tx, 1'b0);
    Reset_n = 1'b0;
    #1;
    check_bit("async reset uart_tx", uart_tx, 1'b1);
    check_bit("async reset uart_state", uart_state, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n  = 1'b1;
    low_cnt  = 0;
    done_cnt = 0;
    repeat (300) begin
      @(negedge Clk);
      if (uart_tx !== 1'b1) low_cnt++;
      if (Tx_Done !== 1'b0) done_cnt++;
    end
    check_int("after mid-frame reset line-low samples", low_cnt, 0);
    check_int("after mid-frame reset Tx_Done samples", done_cnt, 0);
    vq.delete();
    vq.push_back('{3'd4, 8'h5A, 17, 1'b0, 1'b0});
    run_queue("post_reset");

    // Randomised frames against the model.
    vq.delete();
    for (int k = 0; k < 8; k++) begin
      fv.sel   = 3'($urandom_range(0, 7));
      fv.data  = 8'($urandom);
      fv.bc    = model_bit_cyc(CLK_HZ, fv.sel);
      fv.noise = 1'($urandom_range(0, 1));
      fv.chain = 1'($urandom_range(0, 1));
      vq.push_back(fv);
    end
    run_queue("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
